// File: rtl/simt_divergence_ctrl.sv
// SIMT divergence/reconvergence controller: drives pushes and pops on the warp's SIMT stack.
// It also owns the registered active-lane mask and the fetch redirect pulse.
module simt_divergence_ctrl #(
    parameter int unsigned THREADS   = 4,
    parameter logic [31:0] BASE_SYNC = 32'hFFFF_FFFF
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               branch_valid,
    input  logic [THREADS-1:0] taken,
    input  logic [31:0]        taken_addr,
    input  logic [31:0]        fallthru_addr,
    input  logic [31:0]        reconv_addr,
    input  logic               pc_valid,
    input  logic [31:0]        pc,
    output logic               pushEn,
    output logic               popEn,
    output logic [31:0]        newSync,
    output logic [31:0]        newAddr,
    output logic [THREADS-1:0] newMask,
    input  logic [31:0]        currentSync,
    input  logic [31:0]        currentAddr,
    input  logic [THREADS-1:0] currentMask,
    input  logic               overflow,
    input  logic               underflow,
    input  logic               isEmpty,
    output logic [THREADS-1:0] active_mask,
    output logic               redirect_valid,
    output logic [31:0]        redirect_addr,
    output logic               stall,
    output logic               error
);

    typedef enum logic [2:0] {StIdle, StPushNt, StPushT, StPopWait, StError} state_e;

    state_e             state_q;
    logic [THREADS-1:0] active_mask_q, t_q, nt_q;
    logic [31:0]        taken_q, fallthru_q, reconv_q, redirect_addr_q;
    logic               redirect_valid_q, error_q;

    logic [THREADS-1:0] t, nt;
    logic [31:0]        cur_sync;
    logic               divergent, reconv_hit;

    assign t          = taken & active_mask_q;
    assign nt         = ~taken & active_mask_q;
    assign cur_sync   = isEmpty ? BASE_SYNC : currentSync;
    assign divergent  = branch_valid && (|t) && (|nt);
    // A branch in the same cycle squashes the pc, so it cannot trigger a pop.
    assign reconv_hit = !branch_valid && pc_valid && !isEmpty && (pc == currentSync);

    always_comb begin
        pushEn  = 1'b0;
        popEn   = 1'b0;
        stall   = 1'b0;
        newSync = '0;
        newAddr = '0;
        newMask = '0;
        unique case (state_q)
            StIdle: begin
                if (divergent) begin
                    stall   = 1'b1;
                    pushEn  = 1'b1;
                    newSync = cur_sync;
                    newAddr = reconv_addr;
                    newMask = active_mask_q;
                end else if (!branch_valid && reconv_hit) begin
                    stall = 1'b1;
                    popEn = 1'b1;
                end
            end
            StPushNt: begin
                stall   = 1'b1;
                pushEn  = 1'b1;
                newSync = reconv_q;
                newAddr = fallthru_q;
                newMask = nt_q;
            end
            StPushT: begin
                stall   = 1'b1;
                pushEn  = 1'b1;
                newSync = reconv_q;
                newAddr = taken_q;
                newMask = t_q;
            end
            StPopWait: stall = 1'b1;
            StError:   stall = 1'b1;
            default:   stall = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q          <= StIdle;
            active_mask_q    <= '1;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
            error_q          <= 1'b0;
            t_q              <= '0;
            nt_q             <= '0;
            taken_q          <= '0;
            fallthru_q       <= '0;
            reconv_q         <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (branch_valid && !divergent) begin
                        redirect_valid_q <= 1'b1;
                        redirect_addr_q  <= (|t) ? taken_addr : fallthru_addr;
                    end else if (divergent) begin
                        t_q        <= t;
                        nt_q       <= nt;
                        taken_q    <= taken_addr;
                        fallthru_q <= fallthru_addr;
                        reconv_q   <= reconv_addr;
                        if (overflow) begin
                            state_q <= StError;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= StPushNt;
                        end
                    end else if (reconv_hit) begin
                        if (underflow) begin
                            state_q <= StError;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= StPopWait;
                        end
                    end
                end
                StPushNt: begin
                    if (overflow) begin
                        state_q <= StError;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= StPushT;
                    end
                end
                StPushT: begin
                    if (overflow) begin
                        state_q <= StError;
                        error_q <= 1'b1;
                    end else begin
                        redirect_valid_q <= 1'b1;
                        redirect_addr_q  <= taken_q;
                        active_mask_q    <= t_q;
                        state_q          <= StIdle;
                    end
                end
                StPopWait: begin
                    // The stack top already reflects the pop issued last cycle.
                    redirect_valid_q <= 1'b1;
                    redirect_addr_q  <= currentAddr;
                    active_mask_q    <= currentMask;
                    state_q          <= StIdle;
                end
                StError: error_q <= 1'b1;
                default: state_q <= StError;
            endcase
        end
    end

    assign active_mask    = active_mask_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_addr  = redirect_addr_q;
    assign error          = error_q;

endmodule

// File: tb/tb_simt_divergence_ctrl.sv
// Scoreboard bench for simt_divergence_ctrl: a small stack model answers pushes/pops and a
// negedge monitor matches every push, pop and redirect against queued expectations with cycle.
module tb_simt_divergence_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        branch_valid, pc_valid;
    logic [3:0]  taken;
    logic [31:0] taken_addr, fallthru_addr, reconv_addr, pc;
    logic        pushEn, popEn;
    logic [31:0] newSync, newAddr;
    logic [3:0]  newMask;
    logic [31:0] currentSync, currentAddr;
    logic [3:0]  currentMask;
    logic        overflow, underflow, isEmpty;
    logic [3:0]  active_mask;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall, error;

    simt_divergence_ctrl #(.THREADS(4), .BASE_SYNC(32'hFFFF_FFFF)) dut (
        .CLK(CLK), .nRST(nRST), .branch_valid(branch_valid), .taken(taken),
        .taken_addr(taken_addr), .fallthru_addr(fallthru_addr), .reconv_addr(reconv_addr),
        .pc_valid(pc_valid), .pc(pc), .pushEn(pushEn), .popEn(popEn), .newSync(newSync),
        .newAddr(newAddr), .newMask(newMask), .currentSync(currentSync),
        .currentAddr(currentAddr), .currentMask(currentMask), .overflow(overflow),
        .underflow(underflow), .isEmpty(isEmpty), .active_mask(active_mask),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .stall(stall),
        .error(error)
    );

    always #5 CLK = ~CLK;

    // Stack model
    logic [31:0] st_sync [8];
    logic [31:0] st_addr [8];
    logic [3:0]  st_mask [8];
    int          sp;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sp <= 0;
        end else if (pushEn && sp < 8) begin
            st_sync[sp] <= newSync;
            st_addr[sp] <= newAddr;
            st_mask[sp] <= newMask;
            sp          <= sp + 1;
        end else if (popEn && sp > 0) begin
            sp <= sp - 1;
        end
    end

    assign isEmpty     = (sp == 0);
    assign currentSync = (sp > 0) ? st_sync[sp-1] : 32'h0;
    assign currentAddr = (sp > 0) ? st_addr[sp-1] : 32'h0;
    assign currentMask = (sp > 0) ? st_mask[sp-1] : 4'h0;
    assign underflow   = 1'b0;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: kind 0 = push, 1 = pop, 2 = redirect
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  m;
        int          c;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] m, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.m = m; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] m);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d a=%h b=%h m=%b", kind, cyc, a, b, m);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.m != m || e.c != cyc) begin
                n_err++;
                $display("FAIL event: got kind=%0d cyc=%0d a=%h b=%h m=%b, want kind=%0d cyc=%0d a=%h b=%h m=%b",
                         kind, cyc, a, b, m, e.kind, e.c, e.a, e.b, e.m);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (redirect_valid) observe(2, redirect_addr, 32'h0, active_mask);
            if (pushEn) observe(0, newSync, newAddr, newMask);
            if (popEn) observe(1, 32'h0, 32'h0, 4'h0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic branch(input logic [3:0] tk, input logic [31:0] ta, input logic [31:0] ft,
                          input logic [31:0] rc);
        branch_valid  = 1'b1;
        taken         = tk;
        taken_addr    = ta;
        fallthru_addr = ft;
        reconv_addr   = rc;
    endtask

    initial begin
        nRST = 1'b0; branch_valid = 1'b0; pc_valid = 1'b0; pc = '0; taken = '0;
        taken_addr = '0; fallthru_addr = '0; reconv_addr = '0; overflow = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mask", 32'(active_mask), 32'hF);
        chk("rst_rv", 32'(redirect_valid), 0);
        chk("rst_ra", redirect_addr, 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_stall", 32'(stall), 0);
        nRST = 1'b1;
        tick();

        // Reset abandons a divergence in PUSH_NT
        tick();
        branch(4'b0011, 32'h50, 32'h54, 32'h60);
        expect_ev(0, 32'hFFFF_FFFF, 32'h60, 4'b1111, cyc);
        #2 chk("rstseq_stall0", 32'(stall), 1);
        tick();
        branch_valid = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rstseq_mask", 32'(active_mask), 32'hF);
        chk("rstseq_stall", 32'(stall), 0);
        chk("rstseq_rv", 32'(redirect_valid), 0);
        chk("rstseq_err", 32'(error), 0);
        tick();
        nRST = 1'b1;
        repeat (3) tick();

        // Uniform taken, then uniform not-taken
        branch(4'b1111, 32'h100, 32'h104, 32'h0);
        expect_ev(2, 32'h100, 32'h0, 4'b1111, cyc + 1);
        #2 chk("uni_stall", 32'(stall), 0);
        tick();
        branch_valid = 1'b0;
        #2 chk("uni_rv", 32'(redirect_valid), 1);
        tick();
        branch(4'b0000, 32'h180, 32'h104, 32'h0);
        expect_ev(2, 32'h104, 32'h0, 4'b1111, cyc + 1);
        tick();
        branch_valid = 1'b0;
        tick();

        // Divergence on an empty stack
        branch(4'b0101, 32'h200, 32'h104, 32'h300);
        expect_ev(0, 32'hFFFF_FFFF, 32'h300, 4'b1111, cyc);
        expect_ev(0, 32'h300, 32'h104, 4'b1010, cyc + 1);
        expect_ev(0, 32'h300, 32'h200, 4'b0101, cyc + 2);
        expect_ev(2, 32'h200, 32'h0, 4'b0101, cyc + 3);
        #2 chk("div_stall0", 32'(stall), 1);
        tick();
        branch_valid = 1'b0;
        #2 chk("div_stall1", 32'(stall), 1);
        tick();
        #2 chk("div_stall2", 32'(stall), 1);
        tick();
        #2 chk("div_stall3", 32'(stall), 0);
        chk("div_mask", 32'(active_mask), 32'h5);
        tick();

        // Branch beats a same-cycle reconvergence match
        branch(4'b1111, 32'h240, 32'h204, 32'h0);
        pc_valid = 1'b1; pc = 32'h300;
        expect_ev(2, 32'h240, 32'h0, 4'b0101, cyc + 1);
        #2 chk("prio_pop", 32'(popEn), 0);
        tick();
        branch_valid = 1'b0; pc_valid = 1'b0;
        tick();

        // Reconvergence walk
        pc_valid = 1'b1; pc = 32'h300;
        expect_ev(1, 32'h0, 32'h0, 4'h0, cyc);
        expect_ev(2, 32'h104, 32'h0, 4'b1010, cyc + 2);
        tick();
        pc_valid = 1'b0;
        repeat (2) tick();
        pc_valid = 1'b1;
        expect_ev(1, 32'h0, 32'h0, 4'h0, cyc);
        expect_ev(2, 32'h300, 32'h0, 4'b1111, cyc + 2);
        tick();
        pc_valid = 1'b0;
        repeat (2) tick();
        pc_valid = 1'b1;
        #2 chk("walk_nopop", 32'(popEn), 0);
        tick();
        pc_valid = 1'b0;
        tick();

        // Overflow during PUSH_T
        branch(4'b0011, 32'h400, 32'h404, 32'h500);
        expect_ev(0, 32'hFFFF_FFFF, 32'h500, 4'b1111, cyc);
        expect_ev(0, 32'h500, 32'h404, 4'b1100, cyc + 1);
        expect_ev(0, 32'h500, 32'h400, 4'b0011, cyc + 2);
        tick();
        branch_valid = 1'b0;
        tick();
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        #2 chk("flt_err", 32'(error), 1);
        chk("flt_stall", 32'(stall), 1);
        tick();
        branch(4'b0011, 32'h600, 32'h604, 32'h700);
        tick();
        branch_valid = 1'b0;
        pc_valid = 1'b1; pc = 32'h500;
        tick();
        pc_valid = 1'b0;
        #2 chk("flt_err_hold", 32'(error), 1);
        chk("flt_stall_hold", 32'(stall), 1);
        nRST = 1'b0;
        #1;
        chk("flt_rst_err", 32'(error), 0);
        chk("flt_rst_stall", 32'(stall), 0);
        tick();
        nRST = 1'b1;
        repeat (3) tick();

        chk("pending_expect", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simt_divergence_ctrl.md
Name: simt_divergence_ctrl

Overview:
- Per-core SIMT divergence/reconvergence controller that drives the datapath side of the SIMT stack.
- On a resolved branch it compares per-thread outcomes against the current active mask.
- On divergence it pushes three stack entries and redirects fetch; when the warp PC reaches the top-of-stack sync address it pops and resumes the next context.
- Owns the registered active thread mask used by issue/writeback.

Parameters:
THREADS, 4, lanes per warp; width of all masks
BASE_SYNC, 32'hFFFF_FFFF, sync value pushed when stack empty (never matches a PC)

Ports:
CLK  input  1  clock
nRST  input  1  async active-low reset
branch_valid  input  1  branch resolved in EX this cycle
taken  input  THREADS  per-thread branch condition, bit i = lane i
taken_addr  input  32  branch target
fallthru_addr  input  32  branch PC+4
reconv_addr  input  32  immediate post-dominator of the branch
pc_valid  input  1  pc holds next instruction to issue
pc  input  32  PC of next instruction to issue
pushEn, popEn  output  1  stack controls
newSync, newAddr  output  32  pushed entry
newMask  output  THREADS  pushed entry mask
currentSync, currentAddr  input  32  stack top
currentMask  input  THREADS  stack top mask
overflow, underflow, isEmpty  input  1  stack status
active_mask  output  THREADS  registered active lanes
redirect_valid  output  1  one-cycle fetch redirect pulse, registered
redirect_addr  output  32  redirect target, registered
stall  output  1  freeze fetch/issue
error  output  1  sticky stack fault

Behaviour:
- Reset (async, nRST=0): state=IDLE, active_mask=all ones, redirect_valid=0, redirect_addr=0, error=0. Combinational outputs (pushEn, popEn, stall) are 0 in IDLE with no event. Reset mid-sequence abandons any pending push/pop.
- t = taken & active_mask; nt = ~taken & active_mask; cur_sync = isEmpty ? BASE_SYNC : currentSync.
- IDLE:
  - Branch: branch_valid has priority over reconvergence; a pc match in the same cycle is ignored (pc is squashed).
    - Uniform (t==0 or nt==0): no push, stall=0. Next edge: redirect_valid=1, redirect_addr = (t!=0) ? taken_addr : fallthru_addr.
    - Divergent (t!=0 and nt!=0): stall=1, push {cur_sync, reconv_addr, active_mask}; latch t, nt, taken_addr, fallthru_addr, reconv_addr; go to PUSH_NT.
  - Reconvergence (no branch_valid, pc_valid, !isEmpty, pc==currentSync): stall=1, popEn=1; go to POP_WAIT.
  - Otherwise: all controls 0.
- PUSH_NT: stall=1, push {reconv, fallthru, nt}; go to PUSH_T.
- PUSH_T: stall=1, push {reconv, taken, t}. Next edge: redirect_valid=1, redirect_addr=taken, active_mask=t; go to IDLE.
- POP_WAIT: stall=1; stack top now reflects the pop. Next edge: redirect_valid=1, redirect_addr=currentAddr, active_mask=currentMask; go to IDLE.
- Latency: uniform branch redirect 1 cycle after branch_valid. Divergent redirect 3 cycles after. Reconvergence redirect 2 cycles after match.
- Faults: overflow sampled in any push cycle, or underflow in any pop cycle, moves to ERROR at the next edge. ERROR: stall=1, error=1, no push/pop, exit only by reset.
- redirect_valid is high for exactly one cycle per redirect; redirect_addr holds its value until the next redirect.
- branch_valid in a non-IDLE state is ignored (upstream is stalled).
- Masks are bitwise with no arithmetic; addresses are passed through unmodified.

Test Plan:
- Reset: nRST low mid-PUSH_NT -> active_mask=4'b1111, stall=0, redirect_valid=0, error=0; no pushEn after release.
- Uniform branch: mask 1111, taken=1111, taken_addr=0x100 -> no pushEn; next cycle redirect_valid=1, addr=0x100, mask 1111. taken=0000 -> addr=fallthru_addr.
- Divergence: mask 1111, taken=0101, taken=0x200, fallthru=0x104, reconv=0x300, empty stack -> 3 pushes: {FFFFFFFF,0x300,1111}, {0x300,0x104,1010}, {0x300,0x200,0101}; cycle 3 redirect 0x200, mask 0101; stall high cycles 0-2.
- Reconvergence walk: continue from previous test, pc=0x300 -> pop, redirect 0x104, mask 1010. pc=0x300 again -> pop, redirect 0x300, mask 1111. pc=0x300 a third time -> no pop (sync=FFFFFFFF).
- Priority: branch_valid and pc==currentSync in the same cycle -> branch handled, popEn=0.
- Fault: overflow=1 during PUSH_T -> error=1 and stall=1 persist until nRST; no further pushEn or popEn.
